// File: rtl/sha256_header_hasher.sv
// Drives a SHA-256 compression core over an 80-byte header: two padded blocks, plus an optional third block that re-hashes the first digest.
// One header in flight. in_ready stays low until the digest is taken, and out_valid holds while out_ready is low.
module sha256_header_hasher #(
    parameter bit DOUBLE_HASH = 1'b1,
    parameter int TIMEOUT     = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [639:0] in_header,
    output logic         core_enable,
    output logic [511:0] core_data,
    output logic [255:0] core_hash,
    input  logic [255:0] core_hash_out,
    input  logic         core_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest,
    output logic         out_err
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    // Each *_WAIT encoding is its *_START plus one.
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] B1_START = 3'd1;
    localparam logic [2:0] B1_WAIT  = 3'd2;
    localparam logic [2:0] B2_START = 3'd3;
    localparam logic [2:0] B2_WAIT  = 3'd4;
    localparam logic [2:0] B3_START = 3'd5;
    localparam logic [2:0] B3_WAIT  = 3'd6;
    localparam logic [2:0] OUT      = 3'd7;

    logic [2:0]      state;
    logic [WD_W-1:0] wd_cnt;
    logic [127:0]    hdr_tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            hdr_tail    <= '0;
            in_ready    <= 1'b0;
            core_enable <= 1'b0;
            core_data   <= '0;
            core_hash   <= '0;
            out_valid   <= 1'b0;
            out_digest  <= '0;
            out_err     <= 1'b0;
        end else begin
            core_enable <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready    <= 1'b0;
                        hdr_tail    <= in_header[127:0];
                        core_data   <= in_header[639:128];
                        core_hash   <= IV;
                        core_enable <= 1'b1;
                        out_err     <= 1'b0;
                        state       <= B1_START;
                    end
                end
                // core_done here is still the previous block's result.
                B1_START, B2_START, B3_START: begin
                    wd_cnt <= '0;
                    state  <= state + 3'd1;
                end
                B1_WAIT, B2_WAIT, B3_WAIT: begin
                    if (core_done) begin
                        if (state == B1_WAIT) begin
                            core_hash   <= core_hash_out;
                            core_data   <= {hdr_tail, 32'h80000000, 288'h0, 64'd640};
                            core_enable <= 1'b1;
                            state       <= B2_START;
                        end else if (state == B2_WAIT && DOUBLE_HASH) begin
                            out_digest  <= core_hash_out;
                            core_hash   <= IV;
                            core_data   <= {core_hash_out, 32'h80000000, 160'h0, 64'd256};
                            core_enable <= 1'b1;
                            state       <= B3_START;
                        end else begin
                            out_digest <= core_hash_out;
                            out_valid  <= 1'b1;
                            state      <= OUT;
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        out_digest <= '0;
                        out_err    <= 1'b1;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_header_hasher.sv
// Two hashers (double and single SHA-256), each driven by a behavioural compression core with 67-cycle latency.
// Expected digests are pushed as stimulus is issued; a monitor per instance pops and compares on every digest handshake.
module tb_sha256_header_hasher;
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [2047:0] K_ALL = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [639:0] GENESIS = {32'h01000000, 256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
    localparam logic [255:0] GENESIS_DIGEST = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

    typedef struct packed {
        logic [1:0]   inst;
        logic         err;
        logic [255:0] dig;
        logic [15:0]  lat;
        logic [3:0]   nen;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid [2];
    logic         in_ready [2];
    logic [639:0] in_header;
    logic         core_enable [2];
    logic [511:0] core_data [2];
    logic [255:0] core_hash [2];
    logic [255:0] core_hash_out [2];
    logic         core_done [2];
    logic         out_valid [2];
    logic         out_ready;
    logic [255:0] out_digest [2];
    logic         out_err [2];

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   core_mode = 0;  // 0: normal core, 1: core never reports done

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K_ALL[2047-32*i -: 32] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Full SHA-256 of a left-aligned message of nbytes bytes (at most 80).
    function automatic logic [255:0] sha256_bytes(input logic [639:0] msg, input int nbytes);
        logic [1023:0] pad_buf;
        logic [255:0]  h;
        int            nblk;
        pad_buf = '0;
        for (int i = 0; i < nbytes; i++) pad_buf[1023-8*i -: 8] = msg[639-8*i -: 8];
        pad_buf[1023-8*nbytes -: 8] = 8'h80;
        nblk = (nbytes + 9 + 63) / 64;
        pad_buf[1024-512*nblk +: 64] = 64'(nbytes * 8);
        h = IV;
        for (int bi = 0; bi < nblk; bi++) h = sha_compress(h, pad_buf[1023-512*bi -: 512]);
        return h;
    endfunction

    function automatic logic [255:0] sha256d(input logic [639:0] hdr);
        return sha256_bytes({sha256_bytes(hdr, 80), 384'h0}, 32);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        sha256_header_hasher #(.DOUBLE_HASH(gi == 0), .TIMEOUT(255)) dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid[gi]), .in_ready(in_ready[gi]), .in_header(in_header),
            .core_enable(core_enable[gi]), .core_data(core_data[gi]), .core_hash(core_hash[gi]),
            .core_hash_out(core_hash_out[gi]), .core_done(core_done[gi]),
            .out_valid(out_valid[gi]), .out_ready(out_ready),
            .out_digest(out_digest[gi]), .out_err(out_err[gi]));

        // Core: done drops after enable, inputs sampled one cycle later, done rises 67 cycles after the enable cycle.
        logic         busy;
        int           cnt;
        logic [511:0] lat_data;
        logic [255:0] lat_hash;
        always_ff @(posedge clk) begin
            if (rst) begin
                busy <= 1'b0; cnt <= 0; core_done[gi] <= 1'b0; core_hash_out[gi] <= '0;
                lat_data <= '0; lat_hash <= '0;
            end else if (core_enable[gi]) begin
                busy <= 1'b1; cnt <= 1; core_done[gi] <= 1'b0;
            end else if (busy) begin
                cnt <= cnt + 1;
                if (cnt == 1) begin
                    lat_data <= core_data[gi];
                    lat_hash <= core_hash[gi];
                end
                if (cnt == 66) begin
                    busy <= 1'b0;
                    if (core_mode == 0) begin
                        core_done[gi] <= 1'b1;
                        core_hash_out[gi] <= sha_compress(lat_hash, lat_data);
                    end
                end
            end
        end

        int   lat, got_lat, nen;
        bit   trk;
        logic prev_en;
        exp_t e;
        initial begin
            trk = 0; lat = 0; got_lat = 0; nen = 0; prev_en = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    trk = 0; nen = 0; prev_en = 0;
                end else begin
                    if (trk) lat++;
                    if (core_enable[gi]) begin
                        nen++;
                        chk("enable_one_cycle", prev_en, 0);
                        if (nen == 1) chk("b1_chain_iv", core_hash[gi], IV);
                        if (nen == 2) chk("b2_length", core_data[gi][63:0], 64'h280);
                        if (nen == 3) begin
                            chk("b3_length", core_data[gi][63:0], 64'd256);
                            chk("b3_chain_iv", core_hash[gi], IV);
                        end
                    end
                    prev_en = core_enable[gi];
                    if (out_valid[gi]) begin
                        if (trk) begin trk = 0; got_lat = lat; end
                        chk("in_ready_low_in_out", in_ready[gi], 0);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_output", 1, 0);
                        end else begin
                            chk("digest", out_digest[gi], exp_q[0].dig);
                            chk("err", out_err[gi], exp_q[0].err);
                            if (out_ready) begin
                                e = exp_q.pop_front();
                                chk("instance", 2'(gi), e.inst);
                                chk("latency", got_lat, e.lat);
                                chk("enable_count", nen, e.nen);
                            end
                        end
                    end
                    if (in_valid[gi] && in_ready[gi]) begin trk = 1; lat = 1; nen = 0; end
                end
            end
        end
    end

    task automatic push(input int g, input logic err, input logic [255:0] d, input int lat, input int nen);
        exp_t x;
        x.inst = 2'(g); x.err = err; x.dig = d; x.lat = 16'(lat); x.nen = 4'(nen);
        exp_q.push_back(x);
    endtask

    task automatic send(input int g, input logic [639:0] hdr);
        int t;
        @(posedge clk); #1;
        in_header = hdr;
        in_valid[g] = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready[g] && t < 1000) begin @(negedge clk); t++; end
        chk("header_accepted", in_ready[g], 1);
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < max_cycles) begin @(negedge clk); t++; end
        chk("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    logic [639:0] hdr2, hdr3, hdr4;
    int           t, pulses;

    initial begin
        in_valid[0] = 1'b0; in_valid[1] = 1'b0; out_ready = 1'b1; in_header = '0;
        hdr2 = GENESIS; hdr2[31:0] = 32'h00000001;
        hdr3 = GENESIS; hdr3[31:0] = 32'hdeadbeef;
        hdr4 = GENESIS; hdr4[127:96] = 32'h12345678;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_in_ready", in_ready[g], 0);
            chk("rst_core_enable", core_enable[g], 0);
            chk("rst_core_data", core_data[g], 0);
            chk("rst_core_hash", core_hash[g], 0);
            chk("rst_out_valid", out_valid[g], 0);
            chk("rst_out_err", out_err[g], 0);
            chk("rst_out_digest", out_digest[g], 0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // Genesis, double hash: 1 + 3*(1+67) + 1 cycles inclusive of accept and first valid.
        push(0, 1'b0, GENESIS_DIGEST, 206, 3);
        send(0, GENESIS);
        wait_drain(500);

        // Genesis, single hash on the DOUBLE_HASH=0 instance.
        push(1, 1'b0, sha256_bytes(GENESIS, 80), 138, 2);
        send(1, GENESIS);
        wait_drain(500);

        // Back-to-back with the consumer always ready.
        push(0, 1'b0, sha256d(hdr2), 206, 3);
        send(0, hdr2);
        push(0, 1'b0, sha256d(hdr3), 206, 3);
        send(0, hdr3);
        wait_drain(600);

        // Consumer stalls 50 cycles; the digest must hold and no new header may enter.
        @(posedge clk); #1 out_ready = 1'b0;
        push(0, 1'b0, sha256d(hdr4), 206, 3);
        send(0, hdr4);
        @(posedge clk); #1 in_header = GENESIS; in_valid[0] = 1'b1;
        t = 0;
        while (!out_valid[0] && t < 500) begin @(negedge clk); t++; end
        chk("stall_valid_seen", out_valid[0], 1);
        repeat (50) @(negedge clk);
        chk("stall_valid_held", out_valid[0], 1);
        @(posedge clk); #1 in_valid[0] = 1'b0; out_ready = 1'b1;
        wait_drain(100);

        // Core never finishes: error after TIMEOUT cycles in B1_WAIT (1 + 1 + 255 + 1).
        core_mode = 1;
        push(0, 1'b1, 256'h0, 258, 1);
        send(0, GENESIS);
        wait_drain(600);
        core_mode = 0;

        // Reset during B2_WAIT aborts silently; the next header still hashes correctly.
        send(0, hdr3);
        pulses = 0; t = 0;
        while (pulses < 2 && t < 500) begin
            @(negedge clk);
            if (core_enable[0]) pulses++;
            t++;
        end
        chk("reached_block2", pulses, 2);
        repeat (10) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_out_valid", out_valid[0], 0);
        chk("abort_core_enable", core_enable[0], 0);
        chk("abort_in_ready", in_ready[0], 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_idle_ready", in_ready[0], 1);
        chk("abort_no_output", out_valid[0], 0);
        push(0, 1'b0, GENESIS_DIGEST, 206, 3);
        send(0, GENESIS);
        wait_drain(500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
